// File: rtl/crc_chk_pkg.sv
// Shared constants and helpers for the FCS checker and its pending-FCS FIFO.
package crc_chk_pkg;

  localparam int CRC_WIDTH_DEF  = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 32;

  // One extra bit so the level can represent a completely full buffer.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/crc_fcs_fifo.sv
// In-order buffer of received FCS values waiting for their computed CRC.
module crc_fcs_fifo
  import crc_chk_pkg::*;
#(
  parameter int CRC_WIDTH  = CRC_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int LVL_W     = levelWidth(FIFO_DEPTH),
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [CRC_WIDTH-1:0] data_i,
  output logic [CRC_WIDTH-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LVL_W-1:0]     level_o
);

  logic [CRC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 wrEn;
  logic                 rdEn;

  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem[rdPtr_q];

  // A full buffer can still accept a push when the head leaves in the same cycle.
  assign rdEn = pop_i && !empty_o;
  assign wrEn = push_i && (!full_o || rdEn);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (rdEn) rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/crc_fcs_check.sv
// Compares each computed CRC against the oldest pending FCS and keeps pass/fail statistics.
module crc_fcs_check
  import crc_chk_pkg::*;
#(
  parameter int CRC_WIDTH  = CRC_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  localparam int LVL_W     = levelWidth(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CRC_WIDTH-1:0] fcs_in,
  input  logic                 fcs_vld,
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic                 crc_vld,
  input  logic                 clr_cnt,
  output logic                 chk_vld,
  output logic                 chk_ok,
  output logic [CRC_WIDTH-1:0] chk_crc,
  output logic [CRC_WIDTH-1:0] chk_fcs,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 ovf_err,
  output logic                 unf_err
);

  logic [CRC_WIDTH-1:0] headFcs;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 popEn;
  logic                 pushEn;
  logic                 bypass;
  logic                 underflow;
  logic                 overflow;
  logic [CRC_WIDTH-1:0] cmpFcs;
  logic                 matchNow;

  logic                 chkVld_q;
  logic                 chkOk_q;
  logic [CRC_WIDTH-1:0] chkCrc_q;
  logic [CRC_WIDTH-1:0] chkFcs_q;
  logic [CNT_WIDTH-1:0] goodCnt_q, goodCnt_d;
  logic [CNT_WIDTH-1:0] badCnt_q, badCnt_d;
  logic                 ovfErr_q, ovfErr_d;
  logic                 unfErr_q, unfErr_d;

  // An empty buffer with both strobes lets the FCS skip storage entirely.
  assign bypass    = fcs_vld && crc_vld && fifoEmpty;
  assign underflow = crc_vld && fifoEmpty && !fcs_vld;
  assign popEn     = crc_vld && !fifoEmpty;
  assign pushEn    = fcs_vld && !bypass;
  assign overflow  = fcs_vld && fifoFull && !popEn;

  crc_fcs_fifo #(
    .CRC_WIDTH  (CRC_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (fcs_in),
    .data_o  (headFcs),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  always_comb begin
    cmpFcs = '0;
    if (popEn)       cmpFcs = headFcs;
    else if (bypass) cmpFcs = fcs_in;
  end

  assign matchNow = crc_vld && !underflow && (crc_in == cmpFcs);

  // Clear beats a same-cycle increment, but a same-cycle error still sets its flag.
  always_comb begin
    goodCnt_d = goodCnt_q;
    badCnt_d  = badCnt_q;
    ovfErr_d  = ovfErr_q;
    unfErr_d  = unfErr_q;
    if (clr_cnt) begin
      goodCnt_d = '0;
      badCnt_d  = '0;
      ovfErr_d  = 1'b0;
      unfErr_d  = 1'b0;
    end else if (crc_vld) begin
      if (matchNow && !(&goodCnt_q))      goodCnt_d = goodCnt_q + CNT_WIDTH'(1);
      else if (!matchNow && !(&badCnt_q)) badCnt_d  = badCnt_q + CNT_WIDTH'(1);
    end
    if (overflow)  ovfErr_d = 1'b1;
    if (underflow) unfErr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chkVld_q  <= 1'b0;
      chkOk_q   <= 1'b0;
      chkCrc_q  <= '0;
      chkFcs_q  <= '0;
      goodCnt_q <= '0;
      badCnt_q  <= '0;
      ovfErr_q  <= 1'b0;
      unfErr_q  <= 1'b0;
    end else begin
      chkVld_q  <= crc_vld;
      if (crc_vld) begin
        chkOk_q  <= matchNow;
        chkCrc_q <= crc_in;
        chkFcs_q <= cmpFcs;
      end
      goodCnt_q <= goodCnt_d;
      badCnt_q  <= badCnt_d;
      ovfErr_q  <= ovfErr_d;
      unfErr_q  <= unfErr_d;
    end
  end

  assign chk_vld  = chkVld_q;
  assign chk_ok   = chkOk_q;
  assign chk_crc  = chkCrc_q;
  assign chk_fcs  = chkFcs_q;
  assign good_cnt = goodCnt_q;
  assign bad_cnt  = badCnt_q;
  assign ovf_err  = ovfErr_q;
  assign unf_err  = unfErr_q;

endmodule

// File: tb/tb_crc_fcs_check.sv
// Directed self-checking bench for crc_fcs_check with hand-computed expectations.
module tb_crc_fcs_check;

  logic        clk;
  logic        rst;
  logic [15:0] fcs_in;
  logic        fcs_vld;
  logic [15:0] crc_in;
  logic        crc_vld;
  logic        clr_cnt;
  logic        chk_vld;
  logic        chk_ok;
  logic [15:0] chk_crc;
  logic [15:0] chk_fcs;
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
  logic [3:0]  fifo_level;
  logic        ovf_err;
  logic        unf_err;

  int assertCount = 0;
  int failCount   = 0;
  int expGood     = 0;
  int expBad      = 0;

  crc_fcs_check dut (
    .clk        (clk),
    .rst        (rst),
    .fcs_in     (fcs_in),
    .fcs_vld    (fcs_vld),
    .crc_in     (crc_in),
    .crc_vld    (crc_vld),
    .clr_cnt    (clr_cnt),
    .chk_vld    (chk_vld),
    .chk_ok     (chk_ok),
    .chk_crc    (chk_crc),
    .chk_fcs    (chk_fcs),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt),
    .fifo_level (fifo_level),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes; outputs of that edge are visible on return.
  task automatic applyStimulus(input logic fv, input logic [15:0] fval,
                               input logic cv, input logic [15:0] cval, input logic clr);
    fcs_vld = fv;
    fcs_in  = fval;
    crc_vld = cv;
    crc_in  = cval;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    fcs_vld = 1'b0;
    crc_vld = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_good"}, 64'(good_cnt), 64'(expGood));
    checkOutput({tag, "_bad"},  64'(bad_cnt),  64'(expBad));
  endtask

  initial begin
    rst = 1'b0;
    fcs_in = '0; fcs_vld = 1'b0; crc_in = '0; crc_vld = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_chkvld", 64'(chk_vld), 64'd0);
    checkOutput("rst_chkok", 64'(chk_ok), 64'd0);
    checkOutput("rst_chkcrc", 64'(chk_crc), 64'd0);
    checkOutput("rst_flags", 64'({ovf_err, unf_err}), 64'd0);
    checkCounters("rst");
    rst = 1'b1;

    // Single matching frame with a multi-cycle CRC latency.
    applyStimulus(1, 16'h1234, 0, 16'h0, 0);
    checkOutput("single_level1", 64'(fifo_level), 64'd1);
    repeat (5) applyStimulus(0, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 16'h0, 1, 16'h1234, 0);
    expGood++;
    checkOutput("single_vld", 64'(chk_vld), 64'd1);
    checkOutput("single_ok", 64'(chk_ok), 64'd1);
    checkOutput("single_level0", 64'(fifo_level), 64'd0);
    checkCounters("single");
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("single_vld_drop", 64'(chk_vld), 64'd0);
    checkOutput("single_hold_crc", 64'(chk_crc), 64'h1234);

    // Mismatching frame.
    applyStimulus(1, 16'h1234, 0, 16'h0, 0);
    applyStimulus(0, 16'h0, 1, 16'h1235, 0);
    expBad++;
    checkOutput("mis_ok", 64'(chk_ok), 64'd0);
    checkOutput("mis_crc", 64'(chk_crc), 64'h1235);
    checkOutput("mis_fcs", 64'(chk_fcs), 64'h1234);
    checkCounters("mis");

    // Fill to depth, then push+pop while full.
    for (int i = 1; i <= 8; i++) applyStimulus(1, 16'(i), 0, 16'h0, 0);
    checkOutput("fill_level", 64'(fifo_level), 64'd8);
    checkOutput("fill_ovf", 64'(ovf_err), 64'd0);
    applyStimulus(1, 16'h0009, 1, 16'h0001, 0);
    expGood++;
    checkOutput("fullpp_level", 64'(fifo_level), 64'd8);
    checkOutput("fullpp_ovf", 64'(ovf_err), 64'd0);
    checkOutput("fullpp_ok", 64'(chk_ok), 64'd1);
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(0, 16'h0, 1, 16'(i), 0);
      expGood++;
      checkOutput($sformatf("drain_ok_%0d", i), 64'({chk_vld, chk_ok}), 64'b11);
      checkOutput($sformatf("drain_fcs_%0d", i), 64'(chk_fcs), 64'(i));
    end
    checkOutput("drain_level", 64'(fifo_level), 64'd0);
    checkCounters("drain");

    // Overflow drops the extra entry; the following empty pop underflows.
    for (int i = 0; i < 8; i++) applyStimulus(1, 16'(16'h10 + i), 0, 16'h0, 0);
    applyStimulus(1, 16'h0099, 0, 16'h0, 0);
    checkOutput("ovf_flag", 64'(ovf_err), 64'd1);
    checkOutput("ovf_level", 64'(fifo_level), 64'd8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 16'h0, 1, 16'(16'h10 + i), 0);
      expGood++;
    end
    checkOutput("ovf_lastok", 64'(chk_ok), 64'd1);
    checkOutput("ovf_drained", 64'(fifo_level), 64'd0);
    applyStimulus(0, 16'h0, 1, 16'h0000, 0);
    expBad++;
    checkOutput("unf_flag", 64'(unf_err), 64'd1);
    checkOutput("unf_vldok", 64'({chk_vld, chk_ok}), 64'b10);
    checkOutput("unf_fcs", 64'(chk_fcs), 64'd0);
    checkCounters("unf");
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("sticky_flags", 64'({ovf_err, unf_err}), 64'b11);

    // Clear, then bypass on an empty buffer.
    applyStimulus(0, 16'h0, 0, 16'h0, 1);
    expGood = 0; expBad = 0;
    checkOutput("clr_flags", 64'({ovf_err, unf_err}), 64'd0);
    checkCounters("clr");
    applyStimulus(1, 16'hBEEF, 1, 16'hBEEF, 0);
    expGood++;
    checkOutput("byp_ok", 64'({chk_vld, chk_ok}), 64'b11);
    checkOutput("byp_fcs", 64'(chk_fcs), 64'hBEEF);
    checkOutput("byp_level", 64'(fifo_level), 64'd0);
    checkCounters("byp");

    // Clear coincident with a pass, and coincident with an underflow.
    applyStimulus(1, 16'h5555, 0, 16'h0, 0);
    applyStimulus(0, 16'h0, 1, 16'h5555, 1);
    expGood = 0; expBad = 0;
    checkOutput("clrpass_ok", 64'(chk_ok), 64'd1);
    checkCounters("clrpass");
    applyStimulus(0, 16'h0, 1, 16'h0, 1);
    checkOutput("clrunf_flag", 64'(unf_err), 64'd1);
    checkCounters("clrunf");

    // Asynchronous reset with entries pending.
    for (int i = 0; i < 3; i++) applyStimulus(1, 16'(16'hA0 + i), 0, 16'h0, 0);
    checkOutput("pend_level", 64'(fifo_level), 64'd3);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_level", 64'(fifo_level), 64'd0);
    checkOutput("arst_unf", 64'(unf_err), 64'd0);
    checkOutput("arst_chkvld", 64'(chk_vld), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    expGood = 0; expBad = 0;
    applyStimulus(0, 16'h0, 1, 16'h00A0, 0);
    expBad++;
    checkOutput("post_unf", 64'(unf_err), 64'd1);
    checkOutput("post_ok", 64'({chk_vld, chk_ok}), 64'b10);
    checkCounters("post");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
